// File: rtl/mixer_v4_iq_decim_if.sv
// Stream bundle for the IQ mixer/decimator: sample+LO input side, scaled IQ output side
// and the saturation monitors. The mixer sits on the slave modport.
interface mixer_v4_iq_decim_if #(
    parameter int INPUT_WIDTH  = 14,
    parameter int LO_WIDTH     = 14,
    parameter int OUTPUT_WIDTH = 14
);
    logic                           CLEAR;
    logic                           IN_VALID;
    logic signed [INPUT_WIDTH-1:0]  SIGNAL_IN;
    logic signed [LO_WIDTH-1:0]     LO_COS;
    logic signed [LO_WIDTH-1:0]     LO_SIN;
    logic [5:0]                     SHIFT;
    logic [3:0]                     DECIM_LOG2;
    logic                           OUT_VALID;
    logic signed [OUTPUT_WIDTH-1:0] I_OUT;
    logic signed [OUTPUT_WIDTH-1:0] Q_OUT;
    logic                           SAT_FLAG;
    logic [15:0]                    SAT_COUNT;

    modport master (
        output CLEAR, IN_VALID, SIGNAL_IN, LO_COS, LO_SIN, SHIFT, DECIM_LOG2,
        input  OUT_VALID, I_OUT, Q_OUT, SAT_FLAG, SAT_COUNT
    );

    modport slave (
        input  CLEAR, IN_VALID, SIGNAL_IN, LO_COS, LO_SIN, SHIFT, DECIM_LOG2,
        output OUT_VALID, I_OUT, Q_OUT, SAT_FLAG, SAT_COUNT
    );
endinterface

// File: rtl/mixer_v4_iq_decim.sv
// Real-input IQ mixer with integrate-and-dump decimation, rounding shift and saturation.
// Four register stages: multiply, integrate/dump, round, saturate/output.
module mixer_v4_iq_decim #(
    parameter int INPUT_WIDTH  = 14,
    parameter int LO_WIDTH     = 14,
    parameter int OUTPUT_WIDTH = 14,
    parameter int ACC_LOG2_MAX = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mixer_v4_iq_decim_if.slave bus
);
    localparam int PROD_W = INPUT_WIDTH + LO_WIDTH;
    localparam int ACC_W  = PROD_W + ACC_LOG2_MAX;
    localparam int EXT_W  = ACC_W + 1;
    localparam int CNT_W  = ACC_LOG2_MAX + 1;

    localparam logic [3:0] DECIM_MAX = (ACC_LOG2_MAX > 15) ? 4'd15 : 4'(ACC_LOG2_MAX);
    localparam logic [5:0] SHIFT_MAX = (ACC_W - 1 > 63) ? 6'd63 : 6'(ACC_W - 1);
    localparam logic signed [EXT_W-1:0] OUT_MAX =
        {{(EXT_W - OUTPUT_WIDTH + 1){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

    logic signed [PROD_W-1:0]       p_i;
    logic signed [PROD_W-1:0]       p_q;
    logic                           p_valid;

    logic [3:0]                     decim_req;
    logic [3:0]                     d_eff;
    logic [3:0]                     d_eff_q;
    logic [CNT_W-1:0]               cnt;
    logic [CNT_W-1:0]               cnt_last;
    logic signed [ACC_W-1:0]        acc_i;
    logic signed [ACC_W-1:0]        acc_q;
    logic signed [ACC_W-1:0]        nxt_i;
    logic signed [ACC_W-1:0]        nxt_q;
    logic signed [ACC_W-1:0]        sum_i;
    logic signed [ACC_W-1:0]        sum_q;
    logic                           d_valid;

    logic [5:0]                     s;
    logic signed [EXT_W-1:0]        rnd;
    logic signed [EXT_W-1:0]        r_i_nxt;
    logic signed [EXT_W-1:0]        r_q_nxt;
    logic signed [EXT_W-1:0]        r_i;
    logic signed [EXT_W-1:0]        r_q;
    logic                           r_valid;

    logic                           clip_i;
    logic                           clip_q;
    logic signed [OUTPUT_WIDTH-1:0] sat_i;
    logic signed [OUTPUT_WIDTH-1:0] sat_q;
    logic                           out_valid;
    logic signed [OUTPUT_WIDTH-1:0] i_out;
    logic signed [OUTPUT_WIDTH-1:0] q_out;
    logic                           sat_flag;
    logic [15:0]                    sat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_i     <= '0;
            p_q     <= '0;
        end else if (bus.CLEAR) begin
            p_valid <= 1'b0;
        end else begin
            p_valid <= bus.IN_VALID;
            if (bus.IN_VALID) begin
                p_i <= PROD_W'(bus.SIGNAL_IN) * PROD_W'(bus.LO_COS);
                p_q <= PROD_W'(bus.SIGNAL_IN) * PROD_W'(bus.LO_SIN);
            end
        end
    end

    // The block length is fixed by the DECIM_LOG2 seen on the first sample of a block.
    always_comb begin
        decim_req = (bus.DECIM_LOG2 > DECIM_MAX) ? DECIM_MAX : bus.DECIM_LOG2;
        d_eff     = (cnt == '0) ? decim_req : d_eff_q;
        cnt_last  = (CNT_W'(1) << d_eff) - CNT_W'(1);
        nxt_i     = acc_i + ACC_W'(p_i);
        nxt_q     = acc_q + ACC_W'(p_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_eff_q <= '0;
            cnt     <= '0;
            acc_i   <= '0;
            acc_q   <= '0;
            sum_i   <= '0;
            sum_q   <= '0;
            d_valid <= 1'b0;
        end else if (bus.CLEAR) begin
            d_eff_q <= '0;
            cnt     <= '0;
            acc_i   <= '0;
            acc_q   <= '0;
            d_valid <= 1'b0;
        end else begin
            d_valid <= 1'b0;
            if (p_valid) begin
                if (cnt == '0) begin
                    d_eff_q <= decim_req;
                end
                if (cnt == cnt_last) begin
                    sum_i   <= nxt_i;
                    sum_q   <= nxt_q;
                    d_valid <= 1'b1;
                    acc_i   <= '0;
                    acc_q   <= '0;
                    cnt     <= '0;
                end else begin
                    acc_i <= nxt_i;
                    acc_q <= nxt_q;
                    cnt   <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // One extra bit of headroom so the rounding offset cannot wrap a full-scale sum.
    always_comb begin
        s       = (bus.SHIFT > SHIFT_MAX) ? SHIFT_MAX : bus.SHIFT;
        rnd     = (s == 6'd0) ? '0 : (EXT_W'(1) << (s - 6'd1));
        r_i_nxt = (EXT_W'(sum_i) + rnd) >>> s;
        r_q_nxt = (EXT_W'(sum_q) + rnd) >>> s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i     <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
        end else if (bus.CLEAR) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= d_valid;
            if (d_valid) begin
                r_i <= r_i_nxt;
                r_q <= r_q_nxt;
            end
        end
    end

    always_comb begin
        clip_i = (r_i > OUT_MAX) || (r_i < OUT_MIN);
        clip_q = (r_q > OUT_MAX) || (r_q < OUT_MIN);
        if (r_i > OUT_MAX)      sat_i = OUT_MAX[OUTPUT_WIDTH-1:0];
        else if (r_i < OUT_MIN) sat_i = OUT_MIN[OUTPUT_WIDTH-1:0];
        else                    sat_i = r_i[OUTPUT_WIDTH-1:0];
        if (r_q > OUT_MAX)      sat_q = OUT_MAX[OUTPUT_WIDTH-1:0];
        else if (r_q < OUT_MIN) sat_q = OUT_MIN[OUTPUT_WIDTH-1:0];
        else                    sat_q = r_q[OUTPUT_WIDTH-1:0];
    end

    // CLEAR resets the monitors but deliberately keeps the last I/Q result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else if (bus.CLEAR) begin
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else begin
            out_valid <= r_valid;
            if (r_valid) begin
                i_out <= sat_i;
                q_out <= sat_q;
                if (clip_i || clip_q) begin
                    sat_flag <= 1'b1;
                    if (sat_count != 16'hFFFF) begin
                        sat_count <= sat_count + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.OUT_VALID = out_valid;
    assign bus.I_OUT     = i_out;
    assign bus.Q_OUT     = q_out;
    assign bus.SAT_FLAG  = sat_flag;
    assign bus.SAT_COUNT = sat_count;
endmodule

// File: tb/tb_mixer_v4_iq_decim.sv
// Scoreboard bench for mixer_v4_iq_decim: a behavioural block model queues expected
// strobes as samples are driven; a monitor records actual strobes for the tests to compare.
module tb_mixer_v4_iq_decim;
    localparam int IW   = 14;
    localparam int LW   = 14;
    localparam int OW   = 14;
    localparam int AMAX = 8;
    localparam int SMAX = IW + LW + AMAX - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mixer_v4_iq_decim_if #(.INPUT_WIDTH(IW), .LO_WIDTH(LW), .OUTPUT_WIDTH(OW)) bus ();

    mixer_v4_iq_decim #(
        .INPUT_WIDTH(IW), .LO_WIDTH(LW), .OUTPUT_WIDTH(OW), .ACC_LOG2_MAX(AMAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [OW-1:0] i;
        logic signed [OW-1:0] q;
        logic                 flag;
        logic [15:0]          cnt;
        longint               cyc;
    } result_t;

    result_t exp_q[$];
    result_t obs_q[$];
    int      obs_rd     = 0;
    int      compared   = 0;
    int      mismatched = 0;
    longint  cyc        = 0;

    longint  m_acc_i = 0;
    longint  m_acc_q = 0;
    int      m_cnt   = 0;
    int      m_deff  = 0;
    int      m_sat   = 0;
    bit      m_flag  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.OUT_VALID === 1'b1)
            obs_q.push_back('{bus.I_OUT, bus.Q_OUT, bus.SAT_FLAG, bus.SAT_COUNT, cyc});
    end

    function automatic void scale(input longint sum, input int shift,
                                  output logic signed [OW-1:0] y, output bit clip);
        longint d, num, qv, omax, omin;
        int s;
        s    = (shift > SMAX) ? SMAX : shift;
        d    = longint'(1) << s;
        num  = sum + ((s > 0) ? d / 2 : 0);
        qv   = num / d;
        if ((num % d) != 0 && num < 0) qv = qv - 1;
        omax = (longint'(1) << (OW - 1)) - 1;
        omin = -omax - 1;
        clip = (qv > omax) || (qv < omin);
        if (qv > omax)      qv = omax;
        else if (qv < omin) qv = omin;
        y = OW'(qv);
    endfunction

    task automatic model_clear();
        m_acc_i = 0;
        m_acc_q = 0;
        m_cnt   = 0;
        m_sat   = 0;
        m_flag  = 1'b0;
        exp_q.delete();
    endtask

    // Drives one valid sample at a falling edge and advances the block model.
    task automatic applyStimulus(input int sig, input int cs, input int sn);
        logic signed [OW-1:0] ei, eq;
        bit ci, cq;
        bus.IN_VALID  = 1'b1;
        bus.SIGNAL_IN = IW'(sig);
        bus.LO_COS    = LW'(cs);
        bus.LO_SIN    = LW'(sn);
        if (m_cnt == 0) m_deff = (int'(bus.DECIM_LOG2) > AMAX) ? AMAX : int'(bus.DECIM_LOG2);
        m_acc_i += longint'(sig) * longint'(cs);
        m_acc_q += longint'(sig) * longint'(sn);
        if (m_cnt == (1 << m_deff) - 1) begin
            scale(m_acc_i, int'(bus.SHIFT), ei, ci);
            scale(m_acc_q, int'(bus.SHIFT), eq, cq);
            if (ci || cq) begin
                m_flag = 1'b1;
                if (m_sat < 65535) m_sat++;
            end
            exp_q.push_back('{ei, eq, m_flag, 16'(m_sat), cyc + 4});
            m_acc_i = 0;
            m_acc_q = 0;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
        @(negedge clk);
        bus.IN_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while ((obs_q.size() - obs_rd) < exp_q.size() && n < 64) begin
            @(negedge clk);
            n++;
        end
        ok = ((obs_q.size() - obs_rd) >= exp_q.size());
        idle(6);
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.CLEAR      = 1'b0;
        bus.IN_VALID   = 1'b0;
        bus.SIGNAL_IN  = '0;
        bus.LO_COS     = '0;
        bus.LO_SIN     = '0;
        bus.SHIFT      = '0;
        bus.DECIM_LOG2 = '0;
        idle(3);
        compared++;
        if (bus.OUT_VALID !== 1'b0 || bus.I_OUT !== '0 || bus.Q_OUT !== '0 ||
            bus.SAT_FLAG !== 1'b0 || bus.SAT_COUNT !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got V=%b I=%0d Q=%0d F=%b C=%0d, want all 0",
                     bus.OUT_VALID, bus.I_OUT, bus.Q_OUT, bus.SAT_FLAG, bus.SAT_COUNT);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_passthrough();
        result_t e, o;
        bit ok;
        bus.DECIM_LOG2 = 4'd0;
        bus.SHIFT      = 6'd13;
        applyStimulus(8191, 8191, -8192);
        wait_drain(ok);
        compared++;
        if (!ok || (obs_q.size() - obs_rd) != exp_q.size()) begin
            mismatched++;
            $display("[TB] FAIL passthrough_count: got %0d strobes, want %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            compared++;
            if (o.i !== e.i || o.q !== e.q || o.flag !== e.flag || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                mismatched++;
                $display("[TB] FAIL passthrough_out: got I=%0d Q=%0d F=%b C=%0d t=%0d, want I=%0d Q=%0d F=%b C=%0d t=%0d",
                         o.i, o.q, o.flag, o.cnt, o.cyc, e.i, e.q, e.flag, e.cnt, e.cyc);
            end
        end
        compared++;
        if (bus.I_OUT !== 14'sd8190 || bus.Q_OUT !== -14'sd8191 || bus.SAT_FLAG !== 1'b0 || bus.OUT_VALID !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL passthrough_hold: got I=%0d Q=%0d F=%b V=%b, want I=8190 Q=-8191 F=0 V=0",
                     bus.I_OUT, bus.Q_OUT, bus.SAT_FLAG, bus.OUT_VALID);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_saturation();
        result_t e, o;
        bit ok;
        bus.DECIM_LOG2 = 4'd0;
        bus.SHIFT      = 6'd0;
        applyStimulus(100, 100, -100);
        idle(2);
        applyStimulus(100, 100, -100);
        wait_drain(ok);
        compared++;
        if (!ok || (obs_q.size() - obs_rd) != exp_q.size()) begin
            mismatched++;
            $display("[TB] FAIL saturation_count: got %0d strobes, want %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            compared++;
            if (o.i !== e.i || o.q !== e.q || o.flag !== e.flag || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                mismatched++;
                $display("[TB] FAIL saturation_out: got I=%0d Q=%0d F=%b C=%0d t=%0d, want I=%0d Q=%0d F=%b C=%0d t=%0d",
                         o.i, o.q, o.flag, o.cnt, o.cyc, e.i, e.q, e.flag, e.cnt, e.cyc);
            end
        end
        compared++;
        if (bus.I_OUT !== 14'sd8191 || bus.Q_OUT !== -14'sd8192 || bus.SAT_FLAG !== 1'b1 || bus.SAT_COUNT !== 16'd2) begin
            mismatched++;
            $display("[TB] FAIL saturation_final: got I=%0d Q=%0d F=%b C=%0d, want I=8191 Q=-8192 F=1 C=2",
                     bus.I_OUT, bus.Q_OUT, bus.SAT_FLAG, bus.SAT_COUNT);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_decim_gaps();
        result_t e, o;
        bit ok;
        bus.DECIM_LOG2 = 4'd2;
        bus.SHIFT      = 6'd2;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(10, 3, -1);
            idle(k + 1);
        end
        wait_drain(ok);
        compared++;
        if (!ok || (obs_q.size() - obs_rd) != exp_q.size()) begin
            mismatched++;
            $display("[TB] FAIL decim_gaps_count: got %0d strobes, want %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            compared++;
            if (o.i !== e.i || o.q !== e.q || o.flag !== e.flag || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                mismatched++;
                $display("[TB] FAIL decim_gaps_out: got I=%0d Q=%0d F=%b C=%0d t=%0d, want I=%0d Q=%0d F=%b C=%0d t=%0d",
                         o.i, o.q, o.flag, o.cnt, o.cyc, e.i, e.q, e.flag, e.cnt, e.cyc);
            end
        end
        compared++;
        if (bus.I_OUT !== 14'sd30 || bus.Q_OUT !== -14'sd10) begin
            mismatched++;
            $display("[TB] FAIL decim_gaps_value: got I=%0d Q=%0d, want I=30 Q=-10", bus.I_OUT, bus.Q_OUT);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_clear();
        result_t e, o;
        bit ok;
        applyStimulus(10, 3, -1);
        applyStimulus(10, 3, -1);
        bus.CLEAR     = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.SIGNAL_IN = 14'sd10;
        bus.LO_COS    = 14'sd3;
        bus.LO_SIN    = -14'sd1;
        model_clear();
        @(negedge clk);
        bus.CLEAR    = 1'b0;
        bus.IN_VALID = 1'b0;
        compared++;
        if (bus.SAT_FLAG !== 1'b0 || bus.SAT_COUNT !== 16'd0 || bus.I_OUT !== 14'sd30) begin
            mismatched++;
            $display("[TB] FAIL clear_monitors: got F=%b C=%0d I=%0d, want F=0 C=0 I=30",
                     bus.SAT_FLAG, bus.SAT_COUNT, bus.I_OUT);
        end
        for (int k = 0; k < 4; k++) applyStimulus(10, 3, -1);
        wait_drain(ok);
        compared++;
        if (!ok || (obs_q.size() - obs_rd) != exp_q.size()) begin
            mismatched++;
            $display("[TB] FAIL clear_count: got %0d strobes, want %0d", obs_q.size() - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            compared++;
            if (o.i !== e.i || o.q !== e.q || o.flag !== e.flag || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                mismatched++;
                $display("[TB] FAIL clear_out: got I=%0d Q=%0d F=%b C=%0d t=%0d, want I=%0d Q=%0d F=%b C=%0d t=%0d",
                         o.i, o.q, o.flag, o.cnt, o.cyc, e.i, e.q, e.flag, e.cnt, e.cyc);
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_decim_change();
        result_t e, o;
        bit ok;
        bus.DECIM_LOG2 = 4'd2;
        bus.SHIFT      = 6'd2;
        applyStimulus(10, 3, -1);
        idle(1);
        bus.DECIM_LOG2 = 4'd0;
        for (int k = 0; k < 5; k++) applyStimulus(10, 3, -1);
        wait_drain(ok);
        compared++;
        if (!ok || (obs_q.size() - obs_rd) != 3 || exp_q.size() != 3) begin
            mismatched++;
            $display("[TB] FAIL decim_change_count: got %0d strobes, want 3", obs_q.size() - obs_rd);
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            compared++;
            if (o.i !== e.i || o.q !== e.q || o.flag !== e.flag || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                mismatched++;
                $display("[TB] FAIL decim_change_out: got I=%0d Q=%0d F=%b C=%0d t=%0d, want I=%0d Q=%0d F=%b C=%0d t=%0d",
                         o.i, o.q, o.flag, o.cnt, o.cyc, e.i, e.q, e.flag, e.cnt, e.cyc);
            end
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_async_reset();
        result_t e, o;
        bit ok;
        bus.DECIM_LOG2 = 4'd2;
        bus.SHIFT      = 6'd2;
        applyStimulus(1000, 5000, -7000);
        applyStimulus(1000, 5000, -7000);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.OUT_VALID !== 1'b0 || bus.I_OUT !== '0 || bus.Q_OUT !== '0 ||
            bus.SAT_FLAG !== 1'b0 || bus.SAT_COUNT !== 16'd0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_outputs: got V=%b I=%0d Q=%0d F=%b C=%0d, want all 0",
                     bus.OUT_VALID, bus.I_OUT, bus.Q_OUT, bus.SAT_FLAG, bus.SAT_COUNT);
        end
        model_clear();
        m_deff = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < 4; k++) applyStimulus(10, 3, -1);
        wait_drain(ok);
        compared++;
        if (!ok || (obs_q.size() - obs_rd) != 1 || exp_q.size() != 1) begin
            mismatched++;
            $display("[TB] FAIL async_reset_count: got %0d strobes, want 1", obs_q.size() - obs_rd);
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            compared++;
            if (o.i !== e.i || o.q !== e.q || o.flag !== e.flag || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                mismatched++;
                $display("[TB] FAIL async_reset_out: got I=%0d Q=%0d F=%b C=%0d t=%0d, want I=%0d Q=%0d F=%b C=%0d t=%0d",
                         o.i, o.q, o.flag, o.cnt, o.cyc, e.i, e.q, e.flag, e.cnt, e.cyc);
            end
        end
        obs_rd = obs_q.size();
    endtask

    // Largest block and largest shift: both clamp to their maximums.
    task automatic test_clamp();
        result_t e, o;
        bit ok;
        bus.DECIM_LOG2 = 4'd15;
        bus.SHIFT      = 6'd63;
        for (int k = 0; k < 256; k++) applyStimulus(-8192, -8192, 8191);
        wait_drain(ok);
        compared++;
        if (!ok || (obs_q.size() - obs_rd) != 1 || exp_q.size() != 1) begin
            mismatched++;
            $display("[TB] FAIL clamp_count: got %0d strobes, want 1", obs_q.size() - obs_rd);
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            compared++;
            if (o.i !== e.i || o.q !== e.q || o.flag !== e.flag || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                mismatched++;
                $display("[TB] FAIL clamp_out: got I=%0d Q=%0d F=%b C=%0d t=%0d, want I=%0d Q=%0d F=%b C=%0d t=%0d",
                         o.i, o.q, o.flag, o.cnt, o.cyc, e.i, e.q, e.flag, e.cnt, e.cyc);
            end
        end
        compared++;
        if (bus.I_OUT !== 14'sd1 || bus.Q_OUT !== 14'sd0) begin
            mismatched++;
            $display("[TB] FAIL clamp_value: got I=%0d Q=%0d, want I=1 Q=0", bus.I_OUT, bus.Q_OUT);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_back_to_back();
        result_t e, o;
        bit ok;
        bus.DECIM_LOG2 = 4'd1;
        bus.SHIFT      = 6'($urandom_range(0, 20));
        for (int k = 0; k < 24; k++) begin
            applyStimulus(int'($urandom_range(0, 16383)) - 8192,
                          int'($urandom_range(0, 16383)) - 8192,
                          int'($urandom_range(0, 16383)) - 8192);
        end
        wait_drain(ok);
        compared++;
        if (!ok || (obs_q.size() - obs_rd) != 12 || exp_q.size() != 12) begin
            mismatched++;
            $display("[TB] FAIL back_to_back_count: got %0d strobes, want 12", obs_q.size() - obs_rd);
        end
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            compared++;
            if (o.i !== e.i || o.q !== e.q || o.flag !== e.flag || o.cnt !== e.cnt || o.cyc != e.cyc) begin
                mismatched++;
                $display("[TB] FAIL back_to_back_out: got I=%0d Q=%0d F=%b C=%0d t=%0d, want I=%0d Q=%0d F=%b C=%0d t=%0d",
                         o.i, o.q, o.flag, o.cnt, o.cyc, e.i, e.q, e.flag, e.cnt, e.cyc);
            end
        end
        obs_rd = obs_q.size();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_saturation();
        test_decim_gaps();
        test_clear();
        test_decim_change();
        test_async_reset();
        test_clamp();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
